// File: rtl/pad_scan.sv
// Digital-pad scanner: walks the TH/TR select lines through four phases, samples the
// returned nibble after a settle time, and publishes a 16-bit active-low button word.
//
// state  | meaning
// IDLE   | selects parked at 11, waiting for a scan request
// PHASE  | select {TH,TR} = phase index driven, settle counter running
// FINISH | one cycle: publish DATA/PRESENT, pulse DONE
module pad_scan #(
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        REQ,
    input  logic [6:0]  PI,
    output logic [6:0]  PO,
    output logic [6:0]  PDIR,
    output logic        BUSY,
    output logic        DONE,
    output logic        PRESENT,
    output logic [15:0] DATA
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PHASE  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [1:0]  r_phase;
    logic [15:0] r_shadow;
    logic [15:0] r_data;
    logic        r_present;
    logic        r_done;
    logic [3:0]  r_pi_s1;
    logic [3:0]  r_pi_s2;
    logic [1:0]  w_sel;
    logic        w_busy;
    logic        w_pad_id;
    logic        w_unused;

    assign w_unused = ^PI[6:4];

    // Phase-3 low bits read 100 only when a digital pad is answering
    assign w_pad_id = (r_shadow[2:0] == 3'b100);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else if (CE) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_sel  = 2'b11;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (REQ) begin
                    w_next = S_PHASE;
                end
            end
            S_PHASE: begin
                w_sel  = r_phase;
                w_busy = 1'b1;
                if ((r_cnt == 8'd0) && (r_phase == 2'd3)) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= 8'd0;
            r_phase   <= 2'd0;
            r_shadow  <= 16'hFFFF;
            r_data    <= 16'hFFFF;
            r_present <= 1'b0;
            r_done    <= 1'b0;
            r_pi_s1   <= 4'hF;
            r_pi_s2   <= 4'hF;
        end else if (CE) begin
            r_pi_s1 <= PI[3:0];
            r_pi_s2 <= r_pi_s1;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        r_phase <= 2'd0;
                        r_cnt   <= RELOAD;
                    end
                end
                S_PHASE: begin
                    if (r_cnt == 8'd0) begin
                        case (r_phase)
                            2'd0:    r_shadow[15:12] <= r_pi_s2;
                            2'd1:    r_shadow[11:8]  <= r_pi_s2;
                            2'd2:    r_shadow[7:4]   <= r_pi_s2;
                            default: r_shadow[3:0]   <= r_pi_s2;
                        endcase
                        if (r_phase != 2'd3) begin
                            r_phase <= r_phase + 2'd1;
                            r_cnt   <= RELOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_FINISH: begin
                    r_present <= w_pad_id;
                    r_data    <= w_pad_id ? r_shadow : 16'hFFFF;
                    r_done    <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign PO      = {w_sel, 5'b00000};
    assign PDIR    = 7'b1100000;
    assign BUSY    = w_busy;
    assign DONE    = r_done;
    assign PRESENT = r_present;
    assign DATA    = r_data;

endmodule

// File: tb/tb_pad_scan.sv
// Directed bench for pad_scan: a combinational pad model answers the select lines,
// each task drives one scenario and checks hand-computed results.
module tb_pad_scan;

    logic        CLK;
    logic        RST;
    logic        CE;
    logic        REQ;
    logic [6:0]  PI;
    logic [6:0]  PO;
    logic [6:0]  PDIR;
    logic        BUSY;
    logic        DONE;
    logic        PRESENT;
    logic [15:0] DATA;

    logic        pad_nopad;
    int          errors;
    int          checks;

    pad_scan #(.SETTLE_CYC(8)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .REQ(REQ), .PI(PI),
        .PO(PO), .PDIR(PDIR), .BUSY(BUSY), .DONE(DONE),
        .PRESENT(PRESENT), .DATA(DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pad answers A,5,3,C for selects 00,01,10,11; with no pad, select 11 reads F
    always_comb begin
        case (PO[6:5])
            2'b00:   PI = 7'h0A;
            2'b01:   PI = 7'h05;
            2'b10:   PI = 7'h03;
            default: PI = pad_nopad ? 7'h0F : 7'h0C;
        endcase
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Edge j=0 samples REQ; records DONE timing and select/data behaviour during the scan
    task automatic watch(input int ncyc, input logic [15:0] data0,
                         output int done_at, output int done_cnt,
                         output int po_bad, output int data_chg);
        logic [1:0] sel;
        done_at = -1; done_cnt = 0; po_bad = 0; data_chg = 0;
        for (int j = 0; j < ncyc; j++) begin
            tick();
            if (j == 0) REQ = 1'b0;
            if (j < 32) begin
                sel = 2'(j / 8);
                if (PO !== {sel, 5'b0} || BUSY !== 1'b1) po_bad++;
                if (DATA !== data0) data_chg++;
            end
            if (DONE === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; CE = 1'b0; REQ = 1'b1;
        tick(); tick(); tick();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        checks++; if (PO !== 7'b1100000) begin errors++; $display("FAIL reset_po: got %b expected 1100000", PO); end
        checks++; if (PDIR !== 7'b1100000) begin errors++; $display("FAIL reset_pdir: got %b expected 1100000", PDIR); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
        checks++; if (PRESENT !== 1'b0) begin errors++; $display("FAIL reset_present: got %b expected 0", PRESENT); end
        checks++; if (DATA !== 16'hFFFF) begin errors++; $display("FAIL reset_data: got %h expected ffff", DATA); end
        RST = 1'b0; CE = 1'b1; REQ = 1'b0;
        tick();
    endtask

    task automatic test_scan();
        int done_at, done_cnt, po_bad, data_chg;
        REQ = 1'b1;
        watch(40, 16'hFFFF, done_at, done_cnt, po_bad, data_chg);
        checks++; if (done_at != 33) begin errors++; $display("FAIL scan_latency: got %0d expected 33", done_at); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL scan_done_count: got %0d expected 1", done_cnt); end
        checks++; if (po_bad != 0) begin errors++; $display("FAIL scan_select_seq: got %0d bad cycles expected 0", po_bad); end
        checks++; if (data_chg != 0) begin errors++; $display("FAIL scan_data_stable: got %0d changes expected 0", data_chg); end
        checks++; if (DATA !== 16'hA53C) begin errors++; $display("FAIL scan_data: got %h expected a53c", DATA); end
        checks++; if (PRESENT !== 1'b1) begin errors++; $display("FAIL scan_present: got %b expected 1", PRESENT); end
        checks++; if (PO !== 7'b1100000) begin errors++; $display("FAIL scan_po_idle: got %b expected 1100000", PO); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL scan_busy_idle: got %b expected 0", BUSY); end
    endtask

    task automatic test_no_pad();
        int done_at, done_cnt, po_bad, data_chg;
        pad_nopad = 1'b1;
        REQ = 1'b1;
        watch(40, 16'hA53C, done_at, done_cnt, po_bad, data_chg);
        checks++; if (done_at != 33) begin errors++; $display("FAIL nopad_latency: got %0d expected 33", done_at); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL nopad_done_count: got %0d expected 1", done_cnt); end
        checks++; if (DATA !== 16'hFFFF) begin errors++; $display("FAIL nopad_data: got %h expected ffff", DATA); end
        checks++; if (PRESENT !== 1'b0) begin errors++; $display("FAIL nopad_present: got %b expected 0", PRESENT); end
        pad_nopad = 1'b0;
    endtask

    task automatic test_ce_toggle();
        int c, done_c, done_bad, po_bad;
        logic [1:0] sel;
        c = -1; done_c = -1; done_bad = 0; po_bad = 0;
        REQ = 1'b1;
        for (int e = 0; e < 80; e++) begin
            CE = (e % 2 == 0);
            tick();
            if (CE) c++;
            if (c == 0) REQ = 1'b0;
            if (c <= 31) begin
                sel = 2'(c / 8);
                if (PO !== {sel, 5'b0} || BUSY !== 1'b1) po_bad++;
            end
            if (DONE !== (c == 33)) done_bad++;
            if (DONE === 1'b1 && done_c < 0) done_c = c;
        end
        CE = 1'b1;
        checks++; if (done_c != 33) begin errors++; $display("FAIL ce_latency: got %0d expected 33", done_c); end
        checks++; if (done_bad != 0) begin errors++; $display("FAIL ce_done_stretch: got %0d bad cycles expected 0", done_bad); end
        checks++; if (po_bad != 0) begin errors++; $display("FAIL ce_freeze: got %0d bad cycles expected 0", po_bad); end
        checks++; if (DATA !== 16'hA53C) begin errors++; $display("FAIL ce_data: got %h expected a53c", DATA); end
    endtask

    task automatic test_reset_mid();
        int done_at, done_cnt, po_bad, data_chg;
        REQ = 1'b1;
        tick();
        REQ = 1'b0;
        for (int j = 1; j < 20; j++) tick();
        checks++; if (PO !== 7'b1000000) begin errors++; $display("FAIL mid_phase2: got %b expected 1000000", PO); end
        RST = 1'b1;
        tick();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", BUSY); end
        checks++; if (PO !== 7'b1100000) begin errors++; $display("FAIL mid_rst_po: got %b expected 1100000", PO); end
        checks++; if (DATA !== 16'hFFFF) begin errors++; $display("FAIL mid_rst_data: got %h expected ffff", DATA); end
        checks++; if (PRESENT !== 1'b0) begin errors++; $display("FAIL mid_rst_present: got %b expected 0", PRESENT); end
        tick();
        RST = 1'b0; REQ = 1'b1;
        watch(40, 16'hFFFF, done_at, done_cnt, po_bad, data_chg);
        checks++; if (done_at != 33 || done_cnt != 1) begin errors++; $display("FAIL mid_rescan_done: got at %0d count %0d expected at 33 count 1", done_at, done_cnt); end
        checks++; if (po_bad != 0) begin errors++; $display("FAIL mid_rescan_select: got %0d bad cycles expected 0", po_bad); end
        checks++; if (DATA !== 16'hA53C) begin errors++; $display("FAIL mid_rescan_data: got %h expected a53c", DATA); end
    endtask

    task automatic test_back_to_back();
        int d[3];
        int n;
        n = 0; d[0] = -1; d[1] = -1; d[2] = -1;
        REQ = 1'b1;
        for (int j = 0; j < 120; j++) begin
            tick();
            if (j == 0)  REQ = 1'b0;
            if (j == 10) REQ = 1'b1;
            if (j == 11) REQ = 1'b0;
            if (j == 14) REQ = 1'b1;
            if (j == 70) REQ = 1'b0;
            if (DONE === 1'b1) begin
                if (n < 3) d[n] = j;
                n++;
            end
        end
        checks++; if (d[0] != 33) begin errors++; $display("FAIL b2b_first: got %0d expected 33", d[0]); end
        checks++; if (d[1] - d[0] != 34) begin errors++; $display("FAIL b2b_spacing: got %0d expected 34", d[1] - d[0]); end
        checks++; if (d[2] != 101) begin errors++; $display("FAIL b2b_third: got %0d expected 101", d[2]); end
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", n); end
        checks++; if (BUSY !== 1'b0 || DATA !== 16'hA53C) begin errors++; $display("FAIL b2b_end: got busy %b data %h expected busy 0 data a53c", BUSY, DATA); end
    endtask

    initial begin
        errors = 0; checks = 0;
        pad_nopad = 1'b0;
        RST = 1'b1; CE = 1'b0; REQ = 1'b0;
        test_reset();
        test_scan();
        test_no_pad();
        test_ce_toggle();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pad_scan.md
PAD_SCAN -- requirements
Module: pad_scan

Interface
REQ-001 Parameter SETTLE_CYC, default 8: CE-qualified cycles each select phase is held before sampling; legal range 2..255.
REQ-002 CLK  input  1  system clock; single clock domain.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 CE  input  1  clock enable; all state advances only on CLK edges with CE=1.
REQ-005 REQ  input  1  scan request from the system-manager peripheral logic; sampled only in IDLE.
REQ-006 PI  input  7  port pins in; bits 3:0 = pad data nibble (active-low buttons), bits 6:4 unused.
REQ-007 PO  output  7  port pins out; bit 6 = TH, bit 5 = TR, bits 4:0 = 0.
REQ-008 PDIR  output  7  pin direction, 1 = driven; constant 7'b1100000.
REQ-009 BUSY  output  1  high while a scan is in progress.
REQ-010 DONE  output  1  one-CE-cycle pulse when DATA/PRESENT have been updated.
REQ-011 PRESENT  output  1  last completed scan saw a valid digital-pad ID.
REQ-012 DATA  output  16  last completed scan result, active-low buttons; consumed as the system manager's 16-bit pad word.

Function
REQ-013 FSM states: IDLE, PHASE, FINISH.
REQ-014 IDLE: PO[6:5]=2'b11, BUSY=0; on CE with REQ=1, load phase index 0, load settle counter with SETTLE_CYC-1, go to PHASE.
REQ-015 PHASE: BUSY=1; PO[6:5] = {TH,TR} = 00, 01, 10, 11 for phase index 0, 1, 2, 3.
REQ-016 PHASE: counter decrements once per CE cycle; on the CE cycle where the counter is 0, PI[3:0] is sampled into the nibble for the current phase.
REQ-017 Nibble mapping: phase 0 -> DATA[15:12], phase 1 -> [11:8], phase 2 -> [7:4], phase 3 -> [3:0]; nibbles accumulate in a shadow register, and DATA does not change during a scan.
REQ-018 After sampling phases 0..2: increment the phase index, reload the counter with SETTLE_CYC-1, and stay in PHASE.
REQ-019 After sampling phase 3: go to FINISH.
REQ-020 FINISH (one CE cycle): PRESENT = (phase-3 nibble[2:0] == 3'b100).
REQ-021 FINISH: if PRESENT, DATA = shadow word; otherwise DATA = 16'hFFFF.
REQ-022 FINISH: DONE=1 for this cycle only, BUSY=0, next state IDLE.
REQ-023 Latency: REQ sampled at CE cycle t -> PO select 00 and BUSY=1 from t+1 -> DONE at CE cycle t+4*SETTLE_CYC+1.
REQ-024 REQ while BUSY or in FINISH is ignored, not queued.
REQ-025 REQ held high starts a new scan on the first IDLE cycle after FINISH (back-to-back scans).
REQ-026 CE=0 freezes state, counter and all outputs; a DONE pulse stretches across CE=0 cycles until the next CE=1 edge.
REQ-027 PI is registered through two flops before sampling; the settle time covers this delay, so SETTLE_CYC >= 2.
REQ-028 DATA, PRESENT and DONE change only in FINISH or on reset.

Reset
REQ-029 RST=1 at any CLK edge, regardless of CE: state=IDLE, PO=7'b1100000, BUSY=0, DONE=0, PRESENT=0, DATA=16'hFFFF, phase index and counter=0, shadow register=16'hFFFF.
REQ-030 Reset mid-scan aborts the scan with no DONE pulse, and the output values are those of REQ-029.
REQ-031 The first REQ after reset release is accepted at the first CE cycle.

Verification
REQ-032 Pad model returns nibbles A,5,3,C for selects 00,01,10,11; SETTLE_CYC=8; CE=1; REQ pulse -> DONE 33 cycles later, DATA=16'hA53C, PRESENT=1, PO returns to 11.
REQ-033 Pad model returns phase-3 nibble 4'hF (no pad) -> DATA=16'hFFFF, PRESENT=0, DONE pulses once.
REQ-034 CE toggled 1,0,1,0 with the REQ-032 pad model -> same DATA; DONE at the 33rd CE-high cycle; no state change on CE=0 cycles.
REQ-035 RST asserted in phase 2 -> BUSY=0, PO=1100000, DATA=FFFF, no DONE; a fresh REQ then yields DATA=A53C.
REQ-036 REQ pulsed again mid-scan, then REQ held high -> extra pulse ignored; held REQ gives two consecutive scans with DONE 34 cycles apart.
